// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, RV32I funct3 and fault-cause constants for the LSU.
package lsu_pkg;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2, S_RESP = 2'd3} state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_RANGE    = 2'b11;
   function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
      return write ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
   endfunction
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: extracts and extends the addressed byte/half of a loaded word,
// and merges store data into the addressed lane of a previously read word.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   input  logic [XLEN-1:0] i_rdata,
   input  logic [XLEN-1:0] i_merge,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_load,
   output logic [XLEN-1:0] o_store
);
   logic [4:0]      w_bshift;
   logic [4:0]      w_hshift;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic            w_sext;
   logic [XLEN-1:0] w_bmask;
   logic [XLEN-1:0] w_hmask;
   assign w_bshift = {i_addr_lo, 3'b000};
   assign w_hshift = {i_addr_lo[1], 4'b0000};
   assign w_byte   = 8'(i_rdata >> w_bshift);
   assign w_half   = 16'(i_rdata >> w_hshift);
   assign w_sext   = ~i_funct3[2];
   assign w_bmask  = XLEN'(8'hFF) << w_bshift;
   assign w_hmask  = XLEN'(16'hFFFF) << w_hshift;
   assign o_load = (i_funct3[1:0] == 2'b00) ? {{(XLEN-8){w_sext & w_byte[7]}}, w_byte}
                 : (i_funct3[1:0] == 2'b01) ? {{(XLEN-16){w_sext & w_half[15]}}, w_half}
                 : i_rdata;
   assign o_store = (i_funct3[1:0] == 2'b00) ? (i_merge & ~w_bmask) | (XLEN'(i_wdata[7:0]) << w_bshift)
                  : (i_funct3[1:0] == 2'b01) ? (i_merge & ~w_hmask) | (XLEN'(i_wdata[15:0]) << w_hshift)
                  : i_wdata;
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I load/store unit turning byte/half/word accesses into word accesses.
// Define LSU_RANGE_CHECK_EN to fault addresses beyond the memory instead of wrapping.
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic              mem_we,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic [4:0]        resp_rd,
   output logic              resp_err,
   output logic [1:0]        resp_cause
);
   state_t            r_state;
   state_t            w_next;
   logic              r_write;
   logic [2:0]        r_funct3;
   logic [ADDR_W+1:0] r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_merge;
   logic [XLEN-1:0]   r_resp_rdata;
   logic [4:0]        r_resp_rd;
   logic              r_resp_err;
   logic [1:0]        r_resp_cause;
   logic              w_accept;
   logic              w_illegal;
   logic              w_misalign;
   logic              w_range;
   logic              w_fault;
   logic [1:0]        w_cause;
   logic [XLEN-1:0]   w_load;
   logic [XLEN-1:0]   w_store;
   assign w_accept   = req_valid & req_ready;
   assign w_illegal  = f3_illegal(req_write, req_funct3);
   assign w_misalign = f3_misaligned(req_funct3, req_addr[1:0]);
`ifdef LSU_RANGE_CHECK_EN
   assign w_range = |req_addr[XLEN-1:ADDR_W+2];
`else
   logic w_unused_hi;
   assign w_unused_hi = |req_addr[XLEN-1:ADDR_W+2];
   assign w_range     = 1'b0;
`endif
   assign w_fault = w_illegal | w_misalign | w_range;
   assign w_cause = w_illegal ? CAUSE_ILLEGAL : w_misalign ? CAUSE_MISALIGN : CAUSE_RANGE;
   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .i_funct3 (r_funct3),
      .i_addr_lo(r_addr[1:0]),
      .i_rdata  (mem_rdata),
      .i_merge  (r_merge),
      .i_wdata  (r_wdata),
      .o_load   (w_load),
      .o_store  (w_store)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_fault ? S_RESP
                                       : (req_write && req_funct3 == F3_W) ? S_WRITE : S_READ;
         S_READ:  w_next = r_write ? S_WRITE : S_RESP;
         S_WRITE: w_next = S_RESP;
         default: w_next = S_IDLE;
      endcase
   end
   always_comb begin
      req_ready  = (r_state == S_IDLE);
      stall      = req_valid & ~req_ready;
      mem_we     = (r_state == S_WRITE);
      mem_addr   = (r_state == S_READ || r_state == S_WRITE) ? r_addr[ADDR_W+1:2] : '0;
      mem_wdata  = mem_we ? w_store : '0;
      resp_valid = (r_state == S_RESP);
      resp_rdata = r_resp_rdata;
      resp_rd    = r_resp_rd;
      resp_err   = r_resp_err;
      resp_cause = r_resp_cause;
   end
   // Response fields are cleared on accept so stores and faults report zero data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write      <= 1'b0;
         r_funct3     <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rd         <= '0;
         r_merge      <= '0;
         r_resp_rdata <= '0;
         r_resp_rd    <= '0;
         r_resp_err   <= 1'b0;
         r_resp_cause <= CAUSE_NONE;
      end else begin
         if (w_accept) begin
            r_write      <= req_write;
            r_funct3     <= req_funct3;
            r_addr       <= req_addr[ADDR_W+1:0];
            r_wdata      <= req_wdata;
            r_rd         <= req_rd;
            r_resp_rdata <= '0;
            r_resp_rd    <= req_write ? 5'd0 : req_rd;
            r_resp_err   <= w_fault;
            r_resp_cause <= w_fault ? w_cause : CAUSE_NONE;
         end
         if (r_state == S_READ && !r_write) r_resp_rdata <= w_load;
         if (r_state == S_READ && r_write)  r_merge      <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed vectors against a 256-word behavioural data memory.
module tb_lsu_mem_stage;
   import lsu_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_we, stall, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic [1:0]  resp_cause;
   logic [31:0] mem [256];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;
   int          we_cnt = 0;
   logic [7:0]  last_wa = '0;
   logic [31:0] last_wd = '0;
   int          checks = 0, failures = 0;
   int          lat, stall_low, nwe, we_base;
   logic        got;
   logic [31:0] rs_data;
   logic [4:0]  rs_rd;
   logic        rs_err;
   logic [1:0]  rs_cause;
   always #5 clk = ~clk;
   lsu_mem_stage dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .stall(stall), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err), .resp_cause(resp_cause)
   );
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         we_cnt        <= we_cnt + 1;
         last_wa       <= mem_addr;
         last_wd       <= mem_wdata;
      end else if (pre_we) mem[pre_addr] <= pre_data;
   end
   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      checks++;
      if (got_v !== exp_v) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
      end
   endtask
   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask
   // Holds req_valid until the response so stall can be watched for the whole request.
   task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd);
      @(negedge clk);
      req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd; req_valid = 1'b1;
      we_base = we_cnt; lat = 0; stall_low = 0; got = 1'b0;
      @(posedge clk);
      while (!got && lat < 8) begin
         @(negedge clk);
         lat++;
         if (resp_valid) begin
            got = 1'b1; rs_data = resp_rdata; rs_rd = resp_rd; rs_err = resp_err; rs_cause = resp_cause;
         end else if (!stall) stall_low++;
      end
      req_valid = 1'b0;
      nwe = we_cnt - we_base;
      check("resp_seen", 32'(got), 32'd1);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_cause", 32'(resp_cause), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      preload(8'd4, 32'h8899AABB);
      preload(8'd255, 32'h0);
      preload(8'd0, 32'h01020304);
      preload(8'd9, 32'hCAFEF00D);
      run_req(1'b0, F3_B, 32'h11, 32'h0, 5'd5);
      check("lb_lat", 32'(lat), 32'd2);
      check("lb_data", rs_data, 32'hFFFFFFAA);
      check("lb_rd", 32'(rs_rd), 32'd5);
      check("lb_err", 32'(rs_err), 32'd0);
      check("lb_nwe", 32'(nwe), 32'd0);
      run_req(1'b0, F3_BU, 32'h11, 32'h0, 5'd6);
      check("lbu_data", rs_data, 32'h000000AA);
      run_req(1'b0, F3_H, 32'h12, 32'h0, 5'd6);
      check("lh_data", rs_data, 32'hFFFF8899);
      run_req(1'b0, F3_HU, 32'h10, 32'h0, 5'd6);
      check("lhu_data", rs_data, 32'h0000AABB);
      run_req(1'b1, F3_H, 32'h12, 32'h00001234, 5'd3);
      check("sh_lat", 32'(lat), 32'd3);
      check("sh_nwe", 32'(nwe), 32'd1);
      check("sh_wa", 32'(last_wa), 32'd4);
      check("sh_wd", last_wd, 32'h1234AABB);
      check("sh_mem", mem[4], 32'h1234AABB);
      check("sh_stall", 32'(stall_low), 32'd0);
      check("sh_rd", 32'(rs_rd), 32'd0);
      check("sh_data", rs_data, 32'd0);
      run_req(1'b1, F3_B, 32'h13, 32'hFFFFFF55, 5'd0);
      check("sb_lat", 32'(lat), 32'd3);
      check("sb_mem", mem[4], 32'h5534AABB);
      run_req(1'b1, F3_W, 32'h20, 32'hDEADBEEF, 5'd0);
      check("sw_lat", 32'(lat), 32'd2);
      check("sw_nwe", 32'(nwe), 32'd1);
      check("sw_wa", 32'(last_wa), 32'd8);
      check("sw_mem", mem[8], 32'hDEADBEEF);
      run_req(1'b0, F3_W, 32'h20, 32'h0, 5'd7);
      check("lw_data", rs_data, 32'hDEADBEEF);
      check("lw_rd", 32'(rs_rd), 32'd7);
      run_req(1'b1, F3_B, 32'h3FF, 32'h000000AB, 5'd0);
      check("sb_top_mem", mem[255], 32'hAB000000);
      run_req(1'b0, F3_B, 32'h3FF, 32'h0, 5'd1);
      check("lb_top_data", rs_data, 32'hFFFFFFAB);
      run_req(1'b0, F3_W, 32'h22, 32'h0, 5'd2);
      check("mis_err", 32'(rs_err), 32'd1);
      check("mis_cause", 32'(rs_cause), 32'(CAUSE_MISALIGN));
      check("mis_lat", 32'(lat), 32'd1);
      check("mis_nwe", 32'(nwe), 32'd0);
      check("mis_data", rs_data, 32'd0);
      run_req(1'b0, 3'b011, 32'h20, 32'h0, 5'd2);
      check("ill_ld_cause", 32'(rs_cause), 32'(CAUSE_ILLEGAL));
      run_req(1'b1, 3'b011, 32'h20, 32'h0, 5'd0);
      check("ill_st_cause", 32'(rs_cause), 32'(CAUSE_ILLEGAL));
      check("ill_st_nwe", 32'(nwe), 32'd0);
      check("ill_st_mem", mem[8], 32'hDEADBEEF);
      run_req(1'b0, 3'b111, 32'h21, 32'h0, 5'd2);
      check("ill_prio_cause", 32'(rs_cause), 32'(CAUSE_ILLEGAL));
      run_req(1'b1, F3_H, 32'h21, 32'h0, 5'd0);
      check("mis_sh_cause", 32'(rs_cause), 32'(CAUSE_MISALIGN));
      check("mis_sh_nwe", 32'(nwe), 32'd0);
      run_req(1'b0, F3_W, 32'h00001000, 32'h0, 5'd4);
`ifdef LSU_RANGE_CHECK_EN
      check("range_err", 32'(rs_err), 32'd1);
      check("range_cause", 32'(rs_cause), 32'(CAUSE_RANGE));
`else
      check("wrap_err", 32'(rs_err), 32'd0);
      check("wrap_data", rs_data, 32'h01020304);
`endif
      @(negedge clk);
      req_write = 1'b1; req_funct3 = F3_B; req_addr = 32'h24; req_wdata = 32'h11; req_rd = '0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rw_we_high", 32'(mem_we), 32'd1);
      check("rw_addr", 32'(mem_addr), 32'd9);
      rst_n = 1'b0;
      #1;
      check("rw_we_drop", 32'(mem_we), 32'd0);
      @(posedge clk);
      #1;
      check("rw_mem", mem[9], 32'hCAFEF00D);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("rw_ready", 32'(req_ready), 32'd1);
      check("rw_valid", 32'(resp_valid), 32'd0);
      run_req(1'b0, F3_W, 32'h24, 32'h0, 5'd9);
      check("rw_reload", rs_data, 32'hCAFEF00D);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
